// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: the bubble ALU code and the bundle widths.
`ifndef ID_EX_CONSTANT_VALUES
`define ID_EX_CONSTANT_VALUES
`define ALU_OFF 3'b111
`define CTRL_W (6 + ALU_OP_W)
`endif

package id_ex_pipe_reg_pkg;
  localparam int WORD_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALU_OP_W_DEF   = 3;
  localparam int CNT_W_DEF      = 16;
  localparam logic [2:0] ALU_OFF = `ALU_OFF;
endpackage

// File: rtl/id_ex_pipe_reg_en_clr.sv
// Generic pipeline register: async reset and sync clear both load CLR_VAL; clear beats enable.
module pipe_reg_en_clr #(
  parameter int W = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= CLR_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures control and operands from decode, with hold, flush and a
// saturating bubble counter for stall accounting.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ALU_OP_W   = ALU_OP_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  mem_write_in,
  input  logic                  mem_read_in,
  input  logic                  reg_write_in,
  input  logic                  reg_dst_in,
  input  logic                  mem_to_reg_in,
  input  logic                  ALU_src_in,
  input  logic [ALU_OP_W-1:0]   ALU_op_in,
  input  logic [WORD_W-1:0]     pc4_in,
  input  logic [WORD_W-1:0]     rd1_in,
  input  logic [WORD_W-1:0]     rd2_in,
  input  logic [WORD_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  mem_write_out,
  output logic                  mem_read_out,
  output logic                  reg_write_out,
  output logic                  reg_dst_out,
  output logic                  mem_to_reg_out,
  output logic                  ALU_src_out,
  output logic [ALU_OP_W-1:0]   ALU_op_out,
  output logic [WORD_W-1:0]     pc4_out,
  output logic [WORD_W-1:0]     rd1_out,
  output logic [WORD_W-1:0]     rd2_out,
  output logic [WORD_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  valid_out,
  output logic [CNT_W-1:0]      bubble_count
);

  // Stage protocol: flush wins over hold; hold freezes every flop including the counter;
  // otherwise each edge loads. A bubble is a flush edge or a load edge with valid_in=0.
  localparam int CTRL_W = `CTRL_W;
  localparam int DATA_W = 4 * WORD_W + 3 * REG_ADDR_W;
  localparam logic [CTRL_W-1:0] CTRL_CLR = {6'b0, ALU_OP_W'(`ALU_OFF)};

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  assign ctrl_in = {mem_write_in, mem_read_in, reg_write_in, reg_dst_in, mem_to_reg_in,
                    ALU_src_in, ALU_op_in};
  assign data_in = {pc4_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};

  pipe_reg_en_clr #(.W(CTRL_W), .CLR_VAL(CTRL_CLR)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (~hold),
    .clr (flush),
    .d   (ctrl_in),
    .q   (ctrl_out)
  );

  pipe_reg_en_clr #(.W(DATA_W), .CLR_VAL('0)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (~hold),
    .clr (flush),
    .d   (data_in),
    .q   (data_out)
  );

  assign {mem_write_out, mem_read_out, reg_write_out, reg_dst_out, mem_to_reg_out,
          ALU_src_out, ALU_op_out} = ctrl_out;
  assign {pc4_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = data_out;

  logic             valid_q;
  logic             valid_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             bubble_edge;

  always_comb begin
    valid_d     = valid_q;
    count_d     = count_q;
    bubble_edge = flush || (!hold && !valid_in);
    if (flush) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      valid_d = valid_in;
    end
    // Saturate rather than wrap so long stalls never read as zero.
    if (bubble_edge && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign valid_out    = valid_q;
  assign bubble_count = count_q;

endmodule
